// File: rtl/rv_rf_wport_arb.sv
// Register-file write-port arbiter: WB has priority, a secondary writer queues
// into a small FIFO that drains on free port cycles, with starvation bubble request.

module rv_rf_wport_arb_hit (
   input  logic       vld_i,
   input  logic [4:0] waddr_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic [4:0] rd_i,
   output logic       hit_o
);
   // x0 is never a real dependency, so it can never match
   assign hit_o = vld_i && (waddr_i != 5'd0) &&
                  ((waddr_i == rs1_i) || (waddr_i == rs2_i) || (waddr_i == rd_i));
endmodule

module rv_rf_wport_arb #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_wb_rf_wen,
   input  logic [4:0]      i_wb_rf_waddr,
   input  logic [XLEN-1:0] i_wb_rf_wdata,
   input  logic            i_sec_valid,
   output logic            o_sec_ready,
   input  logic [4:0]      i_sec_waddr,
   input  logic [XLEN-1:0] i_sec_wdata,
   input  logic [4:0]      i_id_rs1,
   input  logic [4:0]      i_id_rs2,
   input  logic [4:0]      i_id_rd,
   output logic            o_id_pend_hit,
   output logic            o_stall_req,
   output logic            o_rf_wen,
   output logic [4:0]      o_rf_waddr,
   output logic [XLEN-1:0] o_rf_wdata,
   output logic            o_rf_src
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
   } wr_t;

   wr_t             mem_q [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   starve_q, starve_d;

   logic            wb_real, empty, full, push, pop;
   logic [DEPTH-1:0] hit;
   wr_t             head;

   assign wb_real     = i_wb_rf_wen && (i_wb_rf_waddr != 5'd0);
   assign empty       = (cnt_q == '0);
   assign full        = (cnt_q == CW'(DEPTH));
   assign head        = mem_q[rd_ptr_q];
   assign o_sec_ready = !full;

   // x0 writes complete the handshake but are never stored
   assign push = i_sec_valid && !full && (i_sec_waddr != 5'd0);
   assign pop  = i_rst_n && !wb_real && !empty;

   always_comb begin
      o_rf_wen   = 1'b0;
      o_rf_waddr = i_wb_rf_waddr;
      o_rf_wdata = i_wb_rf_wdata;
      o_rf_src   = 1'b0;
      if (i_rst_n) begin
         if (wb_real) begin
            o_rf_wen = 1'b1;
         end else if (!empty) begin
            o_rf_wen   = 1'b1;
            o_rf_waddr = head.addr;
            o_rf_wdata = head.data;
            o_rf_src   = 1'b1;
         end
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      // only cycles where WB actually blocks a waiting entry count toward starvation
      if (pop || empty)
         starve_d = '0;
      else if (wb_real && (starve_q != SW'(STARVE_MAX)))
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         if (push) begin
            mem_q[wr_ptr_q].addr <= i_sec_waddr;
            mem_q[wr_ptr_q].data <= i_sec_wdata;
         end
      end
   end

   // entry is live when its distance from the head is below the occupancy
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [AW-1:0] off;
      logic          vld;
      assign off = AW'(i) - rd_ptr_q;
      assign vld = ({1'b0, off} < cnt_q);
      rv_rf_wport_arb_hit u_hit (
         .vld_i   (vld),
         .waddr_i (mem_q[i].addr),
         .rs1_i   (i_id_rs1),
         .rs2_i   (i_id_rs2),
         .rd_i    (i_id_rd),
         .hit_o   (hit[i])
      );
   end

   assign o_id_pend_hit = i_rst_n && (|hit);
   assign o_stall_req   = i_rst_n && (starve_q == SW'(STARVE_MAX));

endmodule

// File: tb/tb_rv_rf_wport_arb.sv
// Randomized scoreboard bench for rv_rf_wport_arb against a queue-based model.

module tb_rv_rf_wport_arb;
   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam int SMAX  = 4;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic            i_wb_rf_wen;
   logic [4:0]      i_wb_rf_waddr;
   logic [XLEN-1:0] i_wb_rf_wdata;
   logic            i_sec_valid;
   logic            o_sec_ready;
   logic [4:0]      i_sec_waddr;
   logic [XLEN-1:0] i_sec_wdata;
   logic [4:0]      i_id_rs1, i_id_rs2, i_id_rd;
   logic            o_id_pend_hit, o_stall_req, o_rf_wen, o_rf_src;
   logic [4:0]      o_rf_waddr;
   logic [XLEN-1:0] o_rf_wdata;

   rv_rf_wport_arb #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_wb_rf_wen(i_wb_rf_wen), .i_wb_rf_waddr(i_wb_rf_waddr), .i_wb_rf_wdata(i_wb_rf_wdata),
      .i_sec_valid(i_sec_valid), .o_sec_ready(o_sec_ready),
      .i_sec_waddr(i_sec_waddr), .i_sec_wdata(i_sec_wdata),
      .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
      .o_id_pend_hit(o_id_pend_hit), .o_stall_req(o_stall_req),
      .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata), .o_rf_src(o_rf_src)
   );

   always #5 i_clk = ~i_clk;

   typedef struct { int cyc; logic [4:0] a; logic [XLEN-1:0] d; logic src; } wr_e;
   typedef struct { int cyc; bit chk_rdy; bit rdy; bit stall; bit pend; } st_e;
   typedef struct { logic [4:0] a; logic [XLEN-1:0] d; } ent_t;

   wr_e  wq[$];
   st_e  sq[$];
   ent_t mbuf[$];
   int   starve = 0;
   bit   known = 0;
   bit   started = 0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(string name, longint act, longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // One clock cycle: predict this cycle's outputs from the model, then advance it.
   task automatic step();
      bit   wbr, popped, emp, rdy, pend;
      st_e  s;
      wr_e  w;
      wbr = i_wb_rf_wen && (i_wb_rf_waddr != 0);
      s.cyc = cyc;
      s.chk_rdy = known;
      s.rdy = (mbuf.size() < DEPTH);
      s.stall = 0;
      s.pend = 0;
      if (i_rst_n) begin
         s.stall = (starve == SMAX);
         pend = 0;
         foreach (mbuf[k])
            if (mbuf[k].a != 0 && (mbuf[k].a == i_id_rs1 || mbuf[k].a == i_id_rs2 || mbuf[k].a == i_id_rd))
               pend = 1;
         s.pend = pend;
         if (wbr) begin
            w.cyc = cyc; w.a = i_wb_rf_waddr; w.d = i_wb_rf_wdata; w.src = 0;
            wq.push_back(w);
         end else if (mbuf.size() > 0) begin
            w.cyc = cyc; w.a = mbuf[0].a; w.d = mbuf[0].d; w.src = 1;
            wq.push_back(w);
         end
      end
      sq.push_back(s);
      @(posedge i_clk);
      if (!i_rst_n) begin
         mbuf.delete();
         starve = 0;
         known = 1;
      end else begin
         emp = (mbuf.size() == 0);
         rdy = (mbuf.size() < DEPTH);
         popped = !wbr && !emp;
         if (popped) void'(mbuf.pop_front());
         if (i_sec_valid && rdy && i_sec_waddr != 0)
            mbuf.push_back('{a: i_sec_waddr, d: i_sec_wdata});
         if (popped || emp) starve = 0;
         else if (starve < SMAX) starve++;
      end
      cyc++;
      #1;
   endtask

   task automatic set_in(bit wen, int wa, bit sv, int sa, logic [XLEN-1:0] sd);
      i_wb_rf_wen   = wen;
      i_wb_rf_waddr = 5'(wa);
      i_wb_rf_wdata = $urandom;
      i_sec_valid   = sv;
      i_sec_waddr   = 5'(sa);
      i_sec_wdata   = sd;
   endtask

   task automatic set_id(int r1, int r2, int rd);
      i_id_rs1 = 5'(r1); i_id_rs2 = 5'(r2); i_id_rd = 5'(rd);
   endtask

   // Monitor: per-cycle status check, and a write-queue pop whenever the port fires.
   always @(negedge i_clk) begin
      st_e s;
      wr_e w;
      if (started && sq.size() > 0) begin
         s = sq.pop_front();
         chk("stall_req", o_stall_req, s.stall);
         chk("pend_hit", o_id_pend_hit, s.pend);
         if (s.chk_rdy) chk("sec_ready", o_sec_ready, s.rdy);
         if (o_rf_wen === 1'b1) begin
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL rf_wen: unexpected write cycle %0d addr %0d", s.cyc, o_rf_waddr);
            end else begin
               w = wq.pop_front();
               chk("rf_cycle", s.cyc, w.cyc);
               chk("rf_waddr", o_rf_waddr, w.a);
               chk("rf_wdata", o_rf_wdata, w.d);
               chk("rf_src", o_rf_src, w.src);
            end
         end else begin
            chk("rf_wen_known", (o_rf_wen === 1'b0), 1);
         end
         while (wq.size() > 0 && wq[0].cyc <= s.cyc) begin
            w = wq.pop_front();
            checks++; errors++;
            $display("FAIL rf_wen: missing write cycle %0d addr %0d", w.cyc, w.a);
         end
      end
   end

   initial begin
      i_rst_n = 0;
      set_in(1, 3, 0, 0, 0);
      set_id(0, 0, 0);
      @(posedge i_clk); #1;
      started = 1;
      // reset held with WB active
      repeat (3) step();
      i_rst_n = 1;
      set_in(0, 0, 0, 0, 0);
      step();
      // lone secondary write drains next cycle
      set_in(0, 0, 1, 5, 32'hDEADBEEF); step();
      set_in(0, 0, 0, 0, 0); repeat (2) step();
      // WB saturates the port until the bubble request fires
      set_in(1, 1, 1, 7, 32'h11); step();
      set_in(1, 2, 1, 8, 32'h22); step();
      set_in(1, 3, 1, 10, 32'h33); step();
      for (int i = 0; i < 6; i++) begin set_in(1, 4 + i, 0, 0, 0); step(); end
      set_in(0, 0, 0, 0, 0); repeat (3) step();
      // pending-destination compare
      set_in(1, 1, 1, 9, 32'h99); step();
      set_id(0, 9, 0);
      set_in(1, 2, 0, 0, 0); repeat (2) step();
      set_in(0, 0, 0, 0, 0); repeat (2) step();
      set_id(0, 0, 0);
      // x0 drops and WB-to-x0 frees the port
      set_in(1, 6, 1, 3, 32'h3333); step();
      set_in(1, 0, 1, 0, 32'h0); step();
      set_in(0, 0, 0, 0, 0); step();
      // fill, pop-only, push+pop, then reset while draining
      set_in(1, 1, 1, 11, 32'hA); step();
      set_in(1, 2, 1, 12, 32'hB); step();
      set_in(0, 0, 1, 13, 32'hC); step();
      set_in(0, 0, 1, 14, 32'hD); step();
      set_in(1, 5, 1, 15, 32'hE); step();
      i_rst_n = 0; set_in(0, 0, 0, 0, 0); step();
      i_rst_n = 1; repeat (3) step();
      // randomized traffic with varying WB load and occasional resets
      for (int blk = 0; blk < 15; blk++) begin
         int wbp;
         wbp = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 75 : 97;
         for (int i = 0; i < 200; i++) begin
            i_rst_n = ($urandom_range(0, 299) != 0);
            set_in($urandom_range(0, 99) < wbp, $urandom_range(0, 15),
                   $urandom_range(0, 99) < 50, $urandom_range(0, 15), $urandom);
            set_id($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            step();
         end
      end
      i_rst_n = 1;
      set_in(0, 0, 0, 0, 0);
      repeat (4) step();
      @(negedge i_clk); #1;
      chk("queues_drained", wq.size() + sq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
